// File: rtl/trigger_pkg.sv
// trigger_pkg: capture FSM states and trigger edge encodings shared by the frame buffer blocks.
package trigger_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, WAIT_VBL} state_t;
  localparam logic EDGE_RISING = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;
endpackage

// File: rtl/trigger_detect.sv
// trigger_detect: previous-sample register and level-crossing comparator for one channel.
module trigger_detect
  import trigger_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic                  edge_sel,
  input  logic                  clear,
  output logic                  hit
);
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= '0;
      prev_ok <= 1'b0;
    end else if (clear) begin
      prev_ok <= 1'b0;
    end else if (valid) begin
      prev <= sample;
      prev_ok <= 1'b1;
    end
  // the first sample after a clear has no predecessor and can never fire
  assign hit = valid && prev_ok && ((edge_sel == EDGE_FALLING) ? (prev > level && sample <= level)
                                                               : (prev < level && sample >= level));
endmodule

// File: rtl/trigger_frame_buffer.sv
// trigger_frame_buffer: multi-channel triggered capture into a circular write bank,
// swapped into the display bank during vertical blanking.
module trigger_frame_buffer
  import trigger_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH = 256,
  parameter int CHANNELS = 2,
  parameter int VBLANK_LINES = 6,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sample_valid,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  sample,
  input  logic                                 arm,
  input  logic                                 mode_auto,
  input  logic [DATA_WIDTH-1:0]                trig_level,
  input  logic                                 trig_edge,
  input  logic [CH_W-1:0]                      trig_ch,
  input  logic [ADDR_W-1:0]                    pretrig,
  input  logic [10:0]                          vcount,
  input  logic [CH_W-1:0]                      rd_ch,
  input  logic [ADDR_W-1:0]                    rd_addr,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 ready,
  output logic                                 triggered,
  output logic                                 frame_done,
  output logic                                 frame_valid
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  state_t                 state;
  logic [ADDR_W-1:0]      wr_ptr, fill_cnt, post_cnt, start_ptr, offset, pre_l, rd_off;
  logic [DATA_WIDTH-1:0]  level_l;
  logic                   edge_l, disp_bank, rd_bank, hit, we, swap, load, det_valid, det_clear;
  logic [CH_W-1:0]        ch_l;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] mem [2*DEPTH];
  assign we = sample_valid && (state == PRE || state == WAIT_TRIG || state == POST);
  assign swap = state == WAIT_VBL && vcount < 11'(VBLANK_LINES);
  assign load = (state == IDLE && arm) || (swap && mode_auto);
  assign det_valid = sample_valid && (state == PRE || state == WAIT_TRIG);
  assign det_clear = state == IDLE || state == WAIT_VBL;
  trigger_detect #(.DATA_WIDTH(DATA_WIDTH)) u_detect (
    .clk      (clk),
    .rst      (rst),
    .valid    (det_valid),
    .sample   (sample[ch_l]),
    .level    (level_l),
    .edge_sel (edge_l),
    .clear    (det_clear),
    .hit      (hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      triggered <= 1'b0;
      frame_done <= 1'b0;
      frame_valid <= 1'b0;
      wr_ptr <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      start_ptr <= '0;
      offset <= '0;
      disp_bank <= 1'b0;
      level_l <= '0;
      edge_l <= EDGE_RISING;
      ch_l <= '0;
      pre_l <= '0;
    end else begin
      frame_done <= 1'b0;
      if (we) wr_ptr <= wr_ptr + ONE;
      if (load) begin
        level_l <= trig_level;
        edge_l <= trig_edge;
        ch_l <= trig_ch;
        pre_l <= pretrig;
        fill_cnt <= '0;
      end
      case (state)
        IDLE: if (arm) begin
          state <= PRE;
          ready <= 1'b0;
        end
        PRE: begin
          if (sample_valid) fill_cnt <= fill_cnt + ONE;
          if (fill_cnt == pre_l) state <= WAIT_TRIG;
        end
        WAIT_TRIG: if (hit) begin
          start_ptr <= wr_ptr - pre_l;
          post_cnt <= ~pre_l;
          triggered <= 1'b1;
          state <= (&pre_l) ? WAIT_VBL : POST;
        end
        POST: if (sample_valid) begin
          post_cnt <= post_cnt - ONE;
          if (post_cnt == ONE) state <= WAIT_VBL;
        end
        WAIT_VBL: if (swap) begin
          disp_bank <= ~disp_bank;
          offset <= start_ptr;
          frame_done <= 1'b1;
          frame_valid <= 1'b1;
          triggered <= 1'b0;
          state <= mode_auto ? PRE : IDLE;
          ready <= ~mode_auto;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (we) mem[{~disp_bank, wr_ptr}] <= sample;
  // read through the post-swap bank/offset so the first new-frame data lands with frame_done
  assign rd_bank = swap ? ~disp_bank : disp_bank;
  assign rd_off = swap ? start_ptr : offset;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= mem[{rd_bank, rd_off + rd_addr}][rd_ch];
endmodule
